mac_result_collector: RTL

MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_res_fifo2.sv | 71 +++++++
 rtl/mac_result_collector.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result collector: FSM state encoding,
// MAC output width, 16-bit saturation bounds and default frame geometry.
package mac_pkg;

  localparam int MAC_OUT_W     = 27;
  localparam int FRAME_LEN_DEF = 256;
  localparam int PIPE_LAT_DEF  = 5;

  // Clamp bounds applied to a captured result when saturation is built in.
  localparam logic signed [MAC_OUT_W-1:0] SAT_MAX = 27'sd32767;
  localparam logic signed [MAC_OUT_W-1:0] SAT_MIN = -27'sd32768;

  // Collector FSM: waiting for a frame, waiting out the MAC pipeline,
  // counting frame operations until the final result is on mac_out.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LAT  = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

endpackage

// File: rtl/mac_res_fifo2.sv
// Two-entry result FIFO. The head always lives in r_mem0, so o_data never
// moves while the consumer stalls. A push into a full FIFO is only dropped
// when there is no pop in the same cycle; o_drop flags that case.
//
// Handshake: o_valid means r_mem0 holds a result; an entry leaves only on a
// cycle where o_valid && i_pop, and i_pop with o_valid low does nothing.
module mac_res_fifo2 #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_drop
);

  logic [W-1:0] r_mem0;
  logic [W-1:0] r_mem1;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_full;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign w_full  = (r_count == 2'd2);
  assign o_drop  = i_push && w_full && !w_pop;
  assign o_data  = r_mem0;
  assign o_valid = (r_count != 2'd0);

  // Occupancy and storage update; pops shift the second entry into the head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (i_push) begin
            r_mem0  <= i_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && w_pop) begin
            r_mem0 <= i_data;
          end else if (i_push) begin
            r_mem1  <= i_data;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_mem0 <= r_mem1;
            if (i_push) begin
              r_mem1 <= i_data;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/mac_result_collector.sv
// MAC result collector: follows a MAC frame from its start pulse, samples
// the rounded accumulator output when the last operation's result arrives,
// and queues it in a 2-entry FIFO with a sticky overrun flag.
// Optional build macro: RESULT_SAT_EN clamps captured results to 16 bits
// and reports clamping on res_sat; without it res_sat is constant 0.
module mac_result_collector
  import mac_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [MAC_OUT_W-1:0] mac_out,
  output logic [MAC_OUT_W-1:0]        res_data,
  output logic                        res_sat,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        busy,
  output logic                        overrun,
  output logic [7:0]                  frame_cnt
);

  localparam logic [4:0] PL_W = 5'(PIPE_LAT);
  localparam logic [8:0] FL_W = 9'(FRAME_LEN);

  state_e     r_state;
  logic [3:0] r_cyc_cnt;
  logic [8:0] r_op_cnt;
  logic       r_overrun;
  logic [7:0] r_frame_cnt;

  logic [4:0] w_cyc_inc;
  logic       w_capture;
  logic       w_drop;

  // cyc_cnt is the number of cycles elapsed since the start cycle. The first
  // result is on mac_out PIPE_LAT cycles after start, so ACC (op_cnt=1) is
  // entered as soon as the elapsed count for the next cycle reaches PIPE_LAT;
  // with PIPE_LAT=1 that is straight from IDLE.
  assign w_cyc_inc = {1'b0, r_cyc_cnt} + 5'd1;
  assign w_capture = (r_state == ST_ACC) && (r_op_cnt == FL_W);

  // Frame tracking FSM and its cycle/operation counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cyc_cnt <= 4'd0;
      r_op_cnt  <= 9'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cyc_cnt <= 4'd1;
            r_state   <= (PL_W == 5'd1) ? ST_ACC : ST_LAT;
            r_op_cnt  <= (PL_W == 5'd1) ? 9'd1 : 9'd0;
          end
        end
        ST_LAT: begin
          r_cyc_cnt <= w_cyc_inc[3:0];
          if (w_cyc_inc == PL_W) begin
            r_state  <= ST_ACC;
            r_op_cnt <= 9'd1;
          end
        end
        ST_ACC: begin
          if (w_capture) begin
            r_state   <= ST_IDLE;
            r_cyc_cnt <= 4'd0;
            r_op_cnt  <= 9'd0;
          end else begin
            r_op_cnt <= r_op_cnt + 9'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef RESULT_SAT_EN
  localparam int ENTRY_W = MAC_OUT_W + 1;
  logic                 w_sat;
  logic [MAC_OUT_W-1:0] w_cap_data;
  logic [ENTRY_W-1:0]   w_fifo_in;
  logic [ENTRY_W-1:0]   w_fifo_out;

  // Clamp the captured value to the signed 16-bit range.
  always_comb begin
    w_sat      = 1'b0;
    w_cap_data = mac_out;
    if (mac_out > SAT_MAX) begin
      w_sat      = 1'b1;
      w_cap_data = SAT_MAX;
    end else if (mac_out < SAT_MIN) begin
      w_sat      = 1'b1;
      w_cap_data = SAT_MIN;
    end
  end

  assign w_fifo_in = {w_sat, w_cap_data};
  assign res_sat   = w_fifo_out[MAC_OUT_W];
  assign res_data  = w_fifo_out[MAC_OUT_W-1:0];
`else
  localparam int ENTRY_W = MAC_OUT_W;
  logic [ENTRY_W-1:0] w_fifo_in;
  logic [ENTRY_W-1:0] w_fifo_out;

  assign w_fifo_in = mac_out;
  assign res_sat   = 1'b0;
  assign res_data  = w_fifo_out;
`endif

  mac_res_fifo2 #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_capture),
    .i_data  (w_fifo_in),
    .i_pop   (res_ready),
    .o_data  (w_fifo_out),
    .o_valid (res_valid),
    .o_drop  (w_drop)
  );

  // Frame counter counts every capture, dropped or not; overrun is sticky.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame_cnt <= 8'd0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign overrun   = r_overrun;
  assign frame_cnt = r_frame_cnt;

endmodule
